// File: rtl/tx_safety_gate_if.sv
// Control and amplitude bundle between the watchdog/modulator side and the TX safety gate.
interface tx_safety_gate_if;
  logic        wd_warning;
  logic        wd_triggered;
  logic        rearm;
  logic [15:0] amp_in;
  logic [15:0] amp_out;
  logic        tx_enable;
  logic [1:0]  state;
  logic [7:0]  fault_count;

  modport master (
    output wd_warning, wd_triggered, rearm, amp_in,
    input  amp_out, tx_enable, state, fault_count
  );

  modport slave (
    input  wd_warning, wd_triggered, rearm, amp_in,
    output amp_out, tx_enable, state, fault_count
  );
endinterface

// File: rtl/tx_safety_gate.sv
// Watchdog-driven TX gate: attenuates on warning, ramps the carrier down on trip,
// then holds the RF stage off until a host rearm after a minimum hold time.
module tx_safety_gate #(
  parameter logic [15:0] RAMP_STEP   = 16'd256,
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input logic             clk,
  input logic             rstn,
  tx_safety_gate_if.slave bus
);
  localparam int unsigned HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    WARN  = 2'd1,
    RAMP  = 2'd2,
    SAFE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   amp_q, amp_d, ramp_amp;
  logic          tx_en_q, tx_en_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [7:0]    fault_q, fault_d;

  assign ramp_amp = (amp_q > RAMP_STEP) ? amp_q - RAMP_STEP : 16'd0;

  // Outputs are chosen from the next state so every output register changes
  // together with the state register; ramp entry steps down from the live amp_q.
  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    tx_en_d = tx_en_q;
    hold_d  = '0;
    fault_d = fault_q;

    unique case (state_q)
      ARMED: begin
        if (bus.wd_triggered)    state_d = RAMP;
        else if (bus.wd_warning) state_d = WARN;
      end
      WARN: begin
        if (bus.wd_triggered)     state_d = RAMP;
        else if (!bus.wd_warning) state_d = ARMED;
      end
      RAMP: begin
        if (ramp_amp == 16'd0) state_d = SAFE;
      end
      SAFE: begin
        if (bus.rearm && !bus.wd_triggered && hold_q == HOLD_MAX) state_d = ARMED;
      end
    endcase

    unique case (state_d)
      ARMED: begin
        amp_d   = bus.amp_in;
        tx_en_d = 1'b1;
      end
      WARN: begin
        amp_d   = bus.amp_in >> 1;
        tx_en_d = 1'b1;
      end
      RAMP: begin
        amp_d   = ramp_amp;
        tx_en_d = 1'b1;
      end
      SAFE: begin
        amp_d   = 16'd0;
        tx_en_d = 1'b0;
        if (state_q != SAFE)       hold_d = '0;
        else if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        else                       hold_d = hold_q;
      end
    endcase

    if (state_d == RAMP && state_q != RAMP && fault_q != 8'hFF)
      fault_d = fault_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= SAFE;
      amp_q   <= 16'd0;
      tx_en_q <= 1'b0;
      hold_q  <= '0;
      fault_q <= 8'd0;
    end else begin
      state_q <= state_d;
      amp_q   <= amp_d;
      tx_en_q <= tx_en_d;
      hold_q  <= hold_d;
      fault_q <= fault_d;
    end
  end

  assign bus.amp_out     = amp_q;
  assign bus.tx_enable   = tx_en_q;
  assign bus.state       = state_q;
  assign bus.fault_count = fault_q;
endmodule

// File: tb/tb_tx_safety_gate.sv
// Vector table plus scripted ramp, reset and saturation sequences for tx_safety_gate.
module tb_tx_safety_gate;
  localparam logic [1:0] S_ARMED = 2'd0, S_WARN = 2'd1, S_RAMP = 2'd2, S_SAFE = 2'd3;

  typedef struct packed {
    logic        warn;
    logic        trig;
    logic        rearm;
    logic [15:0] amp_in;
    logic [1:0]  st;
    logic [15:0] amp;
    logic        tx;
    logic [7:0]  fault;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  tx_safety_gate_if bus();

  tx_safety_gate #(.RAMP_STEP(16'd256), .HOLD_CYCLES(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  vec_t       sb[$];
  int         hold_m = 0;
  logic [1:0] prev_st = S_SAFE;

  function automatic vec_t mk(logic w, logic t, logic r, logic [15:0] ai,
                              logic [1:0] st, logic [15:0] a, logic tx, logic [7:0] f);
    vec_t v;
    v.warn = w; v.trig = t; v.rearm = r; v.amp_in = ai;
    v.st = st; v.amp = a; v.tx = tx; v.fault = f;
    return v;
  endfunction

  task automatic chk(input string tag, input string fld, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got 0x%h expected 0x%h", tag, fld, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    bus.wd_warning   = v.warn;
    bus.wd_triggered = v.trig;
    bus.rearm        = v.rearm;
    bus.amp_in       = v.amp_in;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (!rstn)                                hold_m = 0;
    else if (prev_st == S_SAFE && e.st == S_SAFE) hold_m = (hold_m == 8) ? 8 : hold_m + 1;
    else                                      hold_m = 0;
    prev_st = e.st;
    chk(tag, "state",       {14'd0, bus.state},       {14'd0, e.st});
    chk(tag, "amp_out",     bus.amp_out,              e.amp);
    chk(tag, "tx_enable",   {15'd0, bus.tx_enable},   {15'd0, e.tx});
    chk(tag, "fault_count", {8'd0, bus.fault_count},  {8'd0, e.fault});
  endtask

  // Sit in SAFE until the hold is complete, idle one more cycle, then rearm.
  task automatic arm(input logic [15:0] ai, input logic [7:0] f);
    while (hold_m != 8) step(mk(0, 0, 0, ai, S_SAFE, 16'h0, 0, f), "hold_wait");
    step(mk(0, 0, 0, ai, S_SAFE, 16'h0, 0, f), "hold_full_no_rearm");
    step(mk(0, 0, 1, ai, S_ARMED, ai, 1, f), "rearm_accept");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [0:18];
    int   f;

    tbl[0]  = mk(0, 0, 1, 16'h1000, S_SAFE,  16'h0000, 0, 0);
    tbl[1]  = mk(0, 0, 0, 16'h1000, S_SAFE,  16'h0000, 0, 0);
    tbl[2]  = mk(0, 1, 0, 16'h1000, S_SAFE,  16'h0000, 0, 0);
    tbl[3]  = mk(0, 0, 1, 16'h1000, S_SAFE,  16'h0000, 0, 0);
    tbl[4]  = mk(1, 0, 0, 16'h1000, S_SAFE,  16'h0000, 0, 0);
    tbl[5]  = mk(0, 0, 0, 16'h1000, S_SAFE,  16'h0000, 0, 0);
    tbl[6]  = mk(0, 0, 0, 16'h1000, S_SAFE,  16'h0000, 0, 0);
    tbl[7]  = mk(0, 0, 1, 16'h1000, S_SAFE,  16'h0000, 0, 0);
    tbl[8]  = mk(0, 1, 1, 16'h1000, S_SAFE,  16'h0000, 0, 0);
    tbl[9]  = mk(0, 0, 1, 16'h1000, S_ARMED, 16'h1000, 1, 0);
    tbl[10] = mk(0, 0, 1, 16'h1000, S_ARMED, 16'h1000, 1, 0);
    tbl[11] = mk(0, 0, 0, 16'h2345, S_ARMED, 16'h2345, 1, 0);
    tbl[12] = mk(1, 0, 0, 16'h8000, S_WARN,  16'h4000, 1, 0);
    tbl[13] = mk(1, 0, 0, 16'hFFFF, S_WARN,  16'h7FFF, 1, 0);
    tbl[14] = mk(0, 0, 0, 16'h8000, S_ARMED, 16'h8000, 1, 0);
    tbl[15] = mk(1, 0, 0, 16'h0300, S_WARN,  16'h0180, 1, 0);
    tbl[16] = mk(1, 1, 0, 16'hFFFF, S_RAMP,  16'h0080, 1, 1);
    tbl[17] = mk(0, 0, 0, 16'hFFFF, S_SAFE,  16'h0000, 0, 1);
    tbl[18] = mk(0, 0, 1, 16'hFFFF, S_SAFE,  16'h0000, 0, 1);

    rstn = 1'b0;
    step(mk(0, 0, 0, 16'h0000, S_SAFE, 16'h0, 0, 0), "reset_a");
    step(mk(1, 1, 1, 16'hFFFF, S_SAFE, 16'h0, 0, 0), "reset_b");
    rstn = 1'b1;

    for (int i = 0; i < 19; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Full ramp from 0x1000 with a single-cycle trigger pulse.
    rstn = 1'b0;
    step(mk(0, 0, 0, 16'h0000, S_SAFE, 16'h0, 0, 0), "reset_clears_fault");
    rstn = 1'b1;
    arm(16'h1000, 8'd0);
    step(mk(0, 0, 0, 16'h1000, S_ARMED, 16'h1000, 1, 0), "armed_next");
    step(mk(0, 1, 0, 16'h1000, S_RAMP, 16'h0F00, 1, 1), "ramp_k1");
    for (int k = 2; k <= 15; k++)
      step(mk(0, 0, 0, 16'hFFFF, S_RAMP, 16'(32'h1000 - 32'd256 * k), 1, 1), $sformatf("ramp_k%0d", k));
    step(mk(0, 0, 0, 16'hFFFF, S_SAFE, 16'h0000, 0, 1), "ramp_done_safe");

    // Reset in the middle of a ramp.
    arm(16'h1000, 8'd1);
    step(mk(0, 1, 0, 16'h1000, S_RAMP, 16'h0F00, 1, 2), "ramp2_k1");
    for (int k = 2; k <= 8; k++)
      step(mk(0, 1, 0, 16'h1000, S_RAMP, 16'(32'h1000 - 32'd256 * k), 1, 2), $sformatf("ramp2_k%0d", k));
    rstn = 1'b0;
    step(mk(0, 1, 0, 16'h1000, S_SAFE, 16'h0000, 0, 0), "reset_mid_ramp");
    rstn = 1'b1;
    for (int k = 0; k < 3; k++)
      step(mk(0, 0, 0, 16'h1000, S_SAFE, 16'h0000, 0, 0), "no_ramp_resume");

    // 300 trip/rearm cycles: counter must stick at 255.
    f = 0;
    for (int n = 1; n <= 300; n++) begin
      arm(16'h0000, 8'(f));
      f = (f == 255) ? 255 : f + 1;
      step(mk(0, 1, 0, 16'h0000, S_RAMP, 16'h0000, 1, 8'(f)), "sat_ramp_zero");
      step(mk(0, 0, 0, 16'h0000, S_SAFE, 16'h0000, 0, 8'(f)), "sat_safe");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
